// File: rtl/rca_pkg.sv
// rca_pkg: shared types and elaboration helpers for the pipelined ripple-carry
// adder/subtractor.
//   op_t      : operation select (OP_ADD = 0, OP_SUB = 1)
//   n_stages  : number of pipeline stages for a WIDTH/CHUNK split
//   width_ok  : legality of a WIDTH/CHUNK split (whole number of chunks)
package rca_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   function automatic int n_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit width_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/pipelined_rca_addsub_if.sv
// pipelined_rca_addsub_if: operand/result stream bundle of the adder.
//   in_valid/in_ready   : operand beat handshake (a, b, c_in, op)
//   out_valid/out_ready : result beat handshake (s, c_out, ovf)
// master = producer of operands / consumer of results, slave = the adder.
interface pipelined_rca_addsub_if #(
   parameter int WIDTH = 16
);
   import rca_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   op_t              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, op, out_ready,
      input  in_ready, out_valid, s, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, op, out_ready,
      output in_ready, out_valid, s, c_out, ovf
   );

endinterface

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple of full adders.
//   a, b     : chunk operands
//   c_in     : carry into bit 0
//   s        : chunk sum
//   c_out    : carry out of the top bit
//   c_msb_in : carry into the top bit (signed overflow = c_msb_in ^ c_out)
module rca_chunk
   import rca_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [CHUNK:0] c_s;

   // Full-adder ripple; c_s[i] is the carry into bit i.
   always_comb begin
      c_s    = '0;
      s      = '0;
      c_s[0] = c_in;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]     = a[i] ^ b[i] ^ c_s[i];
         c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out    = c_s[CHUNK];
   assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// pipelined_rca_addsub: WIDTH-bit adder/subtractor rippled CHUNK bits per
// pipeline stage (STAGES = WIDTH/CHUNK), latency STAGES, one beat per cycle.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of the operand/result stream
//              ADD: {c_out,s} = a + b + c_in ; SUB: {c_out,s} = a + ~b + 1
//              ovf = carry into MSB ^ carry out of MSB
// A single global stall (advance) freezes every stage while the output beat
// is held. Each stage register carries the result bits finished so far plus
// the operand bits not yet rippled, so the result leaves fully aligned.
module pipelined_rca_addsub
   import rca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_rca_addsub_if.slave bus
);

   localparam int STAGES = n_stages(WIDTH, CHUNK);

   if (!width_ok(WIDTH, CHUNK)) begin : g_bad_split
      $error("pipelined_rca_addsub: WIDTH must be a positive multiple of CHUNK");
   end

   logic             advance_s;
   logic [WIDTH-1:0] bx_s;
   logic             cin0_s;

   // Subtract is a + ~b + 1: invert b and force the stage-0 carry.
   always_comb begin
      bx_s   = bus.b;
      cin0_s = bus.c_in;
      case (bus.op)
         OP_ADD:  begin bx_s = bus.b;  cin0_s = bus.c_in; end
         OP_SUB:  begin bx_s = ~bus.b; cin0_s = 1'b1;     end
         default: begin bx_s = bus.b;  cin0_s = bus.c_in; end
      endcase
   end

   assign advance_s    = !g_stg[STAGES-1].vld_q || bus.out_ready;
   assign bus.in_ready = advance_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int SW = WIDTH - k * CHUNK;   // operand bits entering stage k
      localparam int RW = (k + 1) * CHUNK;     // result bits complete after stage k

      logic [SW-1:0]    src_a_s, src_b_s;
      logic             src_c_s, src_vld_s;
      logic [RW-1:0]    res_in_s;
      logic [CHUNK-1:0] sum_s;
      logic             cout_s, cmsb_s, load_s;
      logic             vld_d, vld_q, cy_d, cy_q;
      logic [RW-1:0]    res_d, res_q;

      if (k == 0) begin : g_src
         assign src_a_s   = bus.a;
         assign src_b_s   = bx_s;
         assign src_c_s   = cin0_s;
         assign src_vld_s = bus.in_valid;
         assign res_in_s  = sum_s;
      end else begin : g_src
         assign src_a_s   = g_stg[k-1].g_fwd.a_q;
         assign src_b_s   = g_stg[k-1].g_fwd.b_q;
         assign src_c_s   = g_stg[k-1].cy_q;
         assign src_vld_s = g_stg[k-1].vld_q;
         assign res_in_s  = {sum_s, g_stg[k-1].res_q};
      end

      rca_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a        (src_a_s[CHUNK-1:0]),
         .b        (src_b_s[CHUNK-1:0]),
         .c_in     (src_c_s),
         .s        (sum_s),
         .c_out    (cout_s),
         .c_msb_in (cmsb_s)
      );

      // Datapath only loads real beats so bubbles never disturb held outputs.
      assign load_s = advance_s && src_vld_s;

      // Next-state for stage valid, carry and accumulated result.
      always_comb begin
         vld_d = vld_q;
         cy_d  = cy_q;
         res_d = res_q;
         if (advance_s) begin
            vld_d = src_vld_s;
         end else begin
            vld_d = vld_q;
         end
         if (load_s) begin
            cy_d  = cout_s;
            res_d = res_in_s;
         end else begin
            cy_d  = cy_q;
            res_d = res_q;
         end
      end

      // Stage valid, carry and result registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= '0;
         end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            res_q <= res_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [SW-CHUNK-1:0] a_d, a_q, b_d, b_q;
         logic                cmsb_unused_s;

         assign cmsb_unused_s = cmsb_s;

         // Skew the not-yet-rippled operand chunks forward.
         always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (load_s) begin
               a_d = src_a_s[SW-1:CHUNK];
               b_d = src_b_s[SW-1:CHUNK];
            end else begin
               a_d = a_q;
               b_d = b_q;
            end
         end

         // Operand skew registers.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_ovf
         logic ovf_d, ovf_q;

         // Signed overflow from the carries around the result MSB.
         always_comb begin
            ovf_d = ovf_q;
            if (load_s) begin
               ovf_d = cmsb_s ^ cout_s;
            end else begin
               ovf_d = ovf_q;
            end
         end

         // Overflow flag register.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign bus.out_valid = g_stg[STAGES-1].vld_q;
   assign bus.s         = g_stg[STAGES-1].res_q;
   assign bus.c_out     = g_stg[STAGES-1].cy_q;
   assign bus.ovf       = g_stg[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// tb_pipelined_rca_addsub: scoreboard bench for pipelined_rca_addsub.
// Two instances share the stimulus: CHUNK=4 (4 stages) and CHUNK=16 (1 stage).
// Each instance has its own expected-result queue, pushed when it accepts a
// beat and popped when it emits one.
module tb_pipelined_rca_addsub;
   import rca_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         ovf;
      int           cyc;
   } exp_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   int       cyc = 0;
   int       n_cmp = 0;
   int       n_err = 0;
   bit       mon_en = 1'b0;
   bit       lat_mode = 1'b0;
   bit       bp_mode = 1'b0;
   int       bp_idx = 0;

   logic         drv_valid = 1'b0;
   logic [W-1:0] drv_a = '0;
   logic [W-1:0] drv_b = '0;
   logic         drv_cin = 1'b0;
   op_t          drv_op = OP_ADD;
   logic         drv_ordy = 1'b1;
   exp_t         drv_exp;

   exp_t sb4 [$];
   exp_t sb1 [$];
   logic         hold_v [2] = '{1'b0, 1'b0};
   logic [W-1:0] hold_s [2];
   logic         hold_c [2];
   logic         hold_o [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_rca_addsub_if #(.WIDTH(W)) if4 ();
   pipelined_rca_addsub_if #(.WIDTH(W)) if1 ();

   assign if4.in_valid = drv_valid;  assign if1.in_valid = drv_valid;
   assign if4.a = drv_a;             assign if1.a = drv_a;
   assign if4.b = drv_b;             assign if1.b = drv_b;
   assign if4.c_in = drv_cin;        assign if1.c_in = drv_cin;
   assign if4.op = drv_op;           assign if1.op = drv_op;
   assign if4.out_ready = drv_ordy;  assign if1.out_ready = drv_ordy;

   pipelined_rca_addsub #(.WIDTH(W), .CHUNK(4))  dut4 (.clk(clk), .rst(rst), .bus(if4));
   pipelined_rca_addsub #(.WIDTH(W), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s; e.c = c; e.ovf = o; e.cyc = 0;
      return e;
   endfunction

   // Reference: wide add, overflow from operand/result signs.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input op_t op);
      logic [W-1:0] bb;
      logic         cc;
      logic [W:0]   full;
      bb   = (op == OP_SUB) ? ~b : b;
      cc   = (op == OP_SUB) ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
      return mk(full[W-1:0], full[W], (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]));
   endfunction

   task automatic mon_step(input int d, input int stg, input logic iv, input logic ir,
                           input logic ov, input logic ordy, input logic [W-1:0] s,
                           input logic c, input logic o);
      exp_t e;
      int   n;
      if (rst) begin
         if (d == 0) sb4.delete(); else sb1.delete();
         hold_v[d] = 1'b0;
         return;
      end
      chk_eq($sformatf("in_ready_st%0d", stg), ir, !ov || ordy);
      if (hold_v[d]) begin
         chk_eq($sformatf("hold_valid_st%0d", stg), ov, 1'b1);
         chk_eq($sformatf("hold_s_st%0d", stg), s, hold_s[d]);
         chk_eq($sformatf("hold_c_st%0d", stg), c, hold_c[d]);
         chk_eq($sformatf("hold_ovf_st%0d", stg), o, hold_o[d]);
      end
      hold_v[d] = ov && !ordy;
      hold_s[d] = s; hold_c[d] = c; hold_o[d] = o;
      if (ov && ordy) begin
         n = (d == 0) ? sb4.size() : sb1.size();
         chk_eq($sformatf("expected_beat_st%0d", stg), n != 0, 1'b1);
         if (n != 0) begin
            if (d == 0) e = sb4.pop_front(); else e = sb1.pop_front();
            chk_eq($sformatf("s_st%0d", stg), s, e.s);
            chk_eq($sformatf("c_out_st%0d", stg), c, e.c);
            chk_eq($sformatf("ovf_st%0d", stg), o, e.ovf);
            if (lat_mode) chk_eq($sformatf("latency_st%0d", stg), cyc - e.cyc, stg);
         end
      end
      if (iv && ir) begin
         e = drv_exp;
         e.cyc = cyc;
         if (d == 0) sb4.push_back(e); else sb1.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_step(0, 4, if4.in_valid, if4.in_ready, if4.out_valid, if4.out_ready,
                  if4.s, if4.c_out, if4.ovf);
         mon_step(1, 1, if1.in_valid, if1.in_ready, if1.out_valid, if1.out_ready,
                  if1.s, if1.c_out, if1.ovf);
      end
   end

   // Downstream readiness: always ready, or the 1,0,0,1 backpressure pattern.
   always @(posedge clk) begin
      #1;
      if (bp_mode) drv_ordy = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
      else         drv_ordy = 1'b1;
      bp_idx++;
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input op_t op, input exp_t e);
      int   budget = 0;
      logic acc = 1'b0;
      drv_a = a; drv_b = b; drv_cin = cin; drv_op = op; drv_exp = e;
      drv_valid = 1'b1;
      while (!acc && budget < 64) begin
         @(negedge clk);
         acc = if4.in_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      chk_eq("send_accepted", acc, 1'b1);
      drv_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [W-1:0] a, b;
      logic         cin;
      op_t          op;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      op  = op_t'($urandom_range(0, 1));
      send(a, b, cin, op, model(a, b, cin, op));
   endtask

   task automatic drain();
      int budget = 0;
      while ((sb4.size() != 0 || sb1.size() != 0) && budget < 200) begin
         @(posedge clk);
         budget++;
      end
      chk_eq("drain_st4", sb4.size(), 0);
      chk_eq("drain_st1", sb1.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for two edges with a valid beat presented.
      rst = 1'b1; drv_valid = 1'b1; drv_a = 16'h1234; drv_b = 16'h5678;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk_eq("rst_out_valid_st4", if4.out_valid, 1'b0);
         chk_eq("rst_s_st4", if4.s, 16'h0000);
         chk_eq("rst_c_out_st4", if4.c_out, 1'b0);
         chk_eq("rst_ovf_st4", if4.ovf, 1'b0);
         chk_eq("rst_in_ready_st4", if4.in_ready, 1'b1);
         chk_eq("rst_out_valid_st1", if1.out_valid, 1'b0);
         chk_eq("rst_in_ready_st1", if1.in_ready, 1'b1);
      end
      rst = 1'b0; drv_valid = 1'b0;
      @(posedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_eq("idle_out_valid_st4", if4.out_valid, 1'b0);
         chk_eq("idle_out_valid_st1", if1.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // Directed arithmetic, exact latency.
      lat_mode = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, OP_ADD, mk(16'h0000, 1'b1, 1'b0));
      drain();
      send(16'h0005, 16'h0007, 1'b1, OP_SUB, mk(16'hFFFE, 1'b0, 1'b0));
      send(16'h8000, 16'h0001, 1'b0, OP_SUB, mk(16'h7FFF, 1'b1, 1'b1));
      send(16'h7FFF, 16'h0001, 1'b0, OP_ADD, mk(16'h8000, 1'b0, 1'b1));
      send(16'h1234, 16'h4321, 1'b1, OP_ADD, mk(16'h5556, 1'b0, 1'b0));
      drain();

      // Streaming with backpressure.
      lat_mode = 1'b0;
      bp_mode  = 1'b1;
      for (int i = 0; i < 20; i++) send_rand();
      drain();
      bp_mode = 1'b0;
      @(posedge clk);
      #1;

      // Reset with beats in flight.
      lat_mode = 1'b1;
      for (int i = 0; i < 3; i++) send_rand();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_eq("flush_out_valid_st4", if4.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(16'h0001, 16'h0002, 1'b0, OP_ADD, mk(16'h0003, 1'b0, 1'b0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
